// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, programmable almost-full/empty thresholds,
// overflow/underflow pulses and an optional first-word-fall-through read port.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AF_LEVEL   = 6,
  parameter int unsigned AE_LEVEL   = 1,
  parameter int unsigned FWFT       = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  W_INC,
  input  logic                  R_INC,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DepthC = (ADDR_WIDTH+1)'(Depth);
  localparam logic [ADDR_WIDTH:0] AfC    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AeC    = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [Depth];
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, udf_q;
  logic                  wr_acc, rd_acc;

  // Acceptance looks only at pre-edge flags; a write never takes the slot a read frees.
  assign wr_acc = W_INC & ~FULL;
  assign rd_acc = R_INC & ~EMPTY;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_acc) wptr_d = wptr_q + ADDR_WIDTH'(1);
    if (rd_acc) rptr_d = rptr_q + ADDR_WIDTH'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= W_INC & FULL;
      udf_q   <= R_INC & EMPTY;
    end
  end

  // Storage is deliberately not cleared by reset.
  always_ff @(posedge CLK) begin
    if (!RST && wr_acc) mem[wptr_q] <= WR_DATA;
  end

  generate
    if (FWFT == 0) begin : g_std_read
      logic [DATA_WIDTH-1:0] rd_q;
      always_ff @(posedge CLK) begin
        if (RST)         rd_q <= '0;
        else if (rd_acc) rd_q <= mem[rptr_q];
      end
      assign RD_DATA = rd_q;
    end else begin : g_fwft_read
      assign RD_DATA = EMPTY ? '0 : mem[rptr_q];
    end
  endgenerate

  assign COUNT        = count_q;
  assign FULL         = (count_q == DepthC);
  assign EMPTY        = (count_q == '0);
  assign ALMOST_FULL  = (count_q >= AfC);
  assign ALMOST_EMPTY = (count_q <= AeC);
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = udf_q;

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO buffer for data paths where producer and consumer share one clock domain, e.g. between the register file, ALU result path and the TX serialiser. Generalises the dual-clock FIFO: the Gray-pointer synchronisers are dropped, and the block adds:
- configurable data width and depth;
- an occupancy count;
- programmable almost-full and almost-empty thresholds;
- overflow and underflow error pulses;
- a selectable first-word-fall-through (FWFT) read mode.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 3, address bits. DEPTH = 2**ADDR_WIDTH words. Legal range 2..10.
- AF_LEVEL, 6, ALMOST_FULL threshold in words. Legal range 1..DEPTH.
- AE_LEVEL, 1, ALMOST_EMPTY threshold in words. Legal range 0..DEPTH-1.
- FWFT, 0. 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- CLK  in  1  single clock. All logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- WR_DATA  in  DATA_WIDTH  write word.
- W_INC  in  1  write request.
- R_INC  in  1  read request (pop).
- RD_DATA  out  DATA_WIDTH  read word.
- FULL  out  1  COUNT == DEPTH.
- EMPTY  out  1  COUNT == 0.
- ALMOST_FULL  out  1  COUNT >= AF_LEVEL.
- ALMOST_EMPTY  out  1  COUNT <= AE_LEVEL.
- COUNT  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- OVERFLOW  out  1  one-cycle pulse: a write was rejected.
- UNDERFLOW  out  1  one-cycle pulse: a read was rejected.

## Operation
- Storage: DEPTH x DATA_WIDTH register array.
- Pointers: write pointer and read pointer, each ADDR_WIDTH bits, wrapping naturally from DEPTH-1 to 0. No Gray coding.
- Occupancy: COUNT register, ADDR_WIDTH+1 bits.
- Write acceptance: a write is accepted when W_INC=1 and FULL=0, both sampled at the same edge. On acceptance, mem[wptr] <= WR_DATA and wptr increments.
- Read acceptance: a read is accepted when R_INC=1 and EMPTY=0. On acceptance, rptr increments.
- Acceptance uses only the pre-edge flags. A write is never accepted into the slot freed by a simultaneous read.
- COUNT update:
  - +1 on a write alone;
  - -1 on a read alone;
  - unchanged when both are accepted, or neither.
- Simultaneous W_INC and R_INC:
  - FULL: the read is accepted, the write is rejected, and OVERFLOW pulses. Next cycle COUNT = DEPTH-1.
  - EMPTY: the write is accepted, the read is rejected, and UNDERFLOW pulses. Next cycle COUNT = 1.
  - Otherwise: both are accepted and COUNT is unchanged.
- OVERFLOW = registered (W_INC & FULL). UNDERFLOW = registered (R_INC & EMPTY). Each is high for exactly one cycle per offending request. Neither is sticky.
- FULL, EMPTY, ALMOST_FULL and ALMOST_EMPTY are decoded from the registered COUNT, so they are glitch-free and valid the cycle after the causing edge.
- Standard read mode (FWFT=0):
  - RD_DATA is a register loaded with mem[rptr] on an accepted read.
  - RD_DATA holds its value otherwise, including across rejected reads.
- FWFT read mode (FWFT=1):
  - RD_DATA = mem[rptr] whenever EMPTY=0, and is forced to 0 while EMPTY=1.
  - R_INC acknowledges (pops) the word currently shown.
- Reset (RST=1 at an edge):
  - wptr = rptr = 0 and COUNT = 0.
  - EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0, OVERFLOW=0, UNDERFLOW=0, RD_DATA=0.
  - Memory contents are not cleared.
  - Reset overrides W_INC and R_INC in the same cycle.
  - Reset applied mid-operation discards all stored words.

## Timing
- Write to EMPTY deassert: 1 cycle. EMPTY falls on the edge that accepts the first write.
- FWFT=1 write to data: the written word appears on RD_DATA in the same cycle that EMPTY falls.
- FWFT=1 pop: after a pop, the next word (or 0 if the FIFO is now empty) appears one cycle later.
- FWFT=0 read latency: RD_DATA is valid in the cycle after the edge that accepted R_INC.
- Flag and COUNT latency: each status output reflects the accepted operations of edge N during cycle N+1.
- Throughput: one write and one read per cycle, sustained.
- Wrap-around: pointers wrap at DEPTH without a bubble. Data order is preserved across the wrap.
- Combinational paths: none from inputs to outputs. In FWFT mode, the only combinational read path is mem[rptr] to RD_DATA.

## Test plan
- Reset then idle: after RST, COUNT=0, EMPTY=1, ALMOST_EMPTY=1, FULL=0, RD_DATA=0. Holds with no requests.
- Fill and drain, defaults, FWFT=0:
  - Write 0x01..0x08: FULL=1 and COUNT=8 after the 8th edge. ALMOST_FULL asserts when COUNT reaches 6.
  - Read 8 words: RD_DATA returns 0x01..0x08, each one cycle after its R_INC. EMPTY=1 at the end.
- Overflow and underflow:
  - W_INC while FULL: OVERFLOW pulses for 1 cycle, COUNT stays 8, and data is unchanged.
  - R_INC while EMPTY: UNDERFLOW pulses for 1 cycle and RD_DATA holds its value.
- Simultaneous requests:
  - Both while FULL: COUNT becomes 7, OVERFLOW=1.
  - Both while EMPTY: COUNT becomes 1, UNDERFLOW=1.
  - Both at COUNT=4: COUNT stays 4 and order is preserved.
- Wrap-around: DATA_WIDTH=16, ADDR_WIDTH=2. Stream 20 words with random W_INC and R_INC. The scoreboard matches every word and COUNT never exceeds 4.
- FWFT=1:
  - Write 0xA5: RD_DATA=0xA5 in the same cycle EMPTY falls.
  - Pop: RD_DATA=0 and EMPTY=1 the next cycle.
  - Assert RST with 3 words stored: COUNT=0 and RD_DATA=0 the next cycle.
